// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating modes, FSM states
// and a helper that identifies modes usable by the multi-step sequencer.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_SHR   = 3'd3,
        MODE_ROTL  = 3'd4,
        MODE_ROTR  = 3'd5,
        MODE_CNTUP = 3'd6,
        MODE_CNTDN = 3'd7
    } mode_t;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    function automatic logic is_seq_mode(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/usr_step_ctr.sv
// Loadable down-counter holding the remaining sequencer steps; the zero flag
// marks the final step.
module usr_step_ctr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          dec,
    input  logic          clear,
    output logic [AW-1:0] cnt,
    output logic          zero
);

    logic [AW-1:0] cnt_d;
    logic [AW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with load/shift/rotate/count modes and a multi-step
// shift/rotate sequencer started by a single Start pulse.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0,
    localparam int              AW      = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Set,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             Sin,
    input  logic             Start,
    input  logic [AW-1:0]    Amount,
    output logic [WIDTH-1:0] Q,
    output logic             SoutL,
    output logic             SoutR,
    output logic             Busy,
    output logic             Done,
    output logic             Wrap
);

    // Result is {wrap, next_q}; wrap flags a count crossing the modulus.
    function automatic logic [WIDTH:0] step_fn(input mode_t m, input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] d, input logic sin);
        logic [WIDTH:0] r;
        r = {1'b0, q};
        case (m)
            MODE_HOLD:  r = {1'b0, q};
            MODE_LOAD:  r = {1'b0, d};
            MODE_SHL:   r = {1'b0, q[WIDTH-2:0], sin};
            MODE_SHR:   r = {1'b0, sin, q[WIDTH-1:1]};
            MODE_ROTL:  r = {1'b0, q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR:  r = {1'b0, q[0], q[WIDTH-1:1]};
            MODE_CNTUP: r = {(q == '1), q + WIDTH'(1)};
            MODE_CNTDN: r = {(q == '0), q - WIDTH'(1)};
            default:    r = {1'b0, q};
        endcase
        return r;
    endfunction

    mode_t            mode_in;
    state_t           state_d, state_q;
    mode_t            op_d, op_q;
    logic [WIDTH-1:0] q_d, q_q;
    logic             done_d, done_q;
    logic             wrap_d, wrap_q;
    logic [AW-1:0]    step_cnt;
    logic             ctr_load, ctr_dec, ctr_clear, ctr_zero;
    logic [AW-1:0]    ctr_cnt;
    logic [WIDTH:0]   seq_res, single_res;

    assign mode_in = mode_t'(Mode);

    // Shifts past WIDTH steps are indistinguishable, so their count saturates.
    always_comb begin
        step_cnt = Amount;
        if ((mode_in == MODE_SHL) || (mode_in == MODE_SHR)) begin
            if (Amount > AW'(WIDTH)) begin
                step_cnt = AW'(WIDTH);
            end
        end
    end

    assign seq_res    = step_fn(op_q, q_q, D, Sin);
    assign single_res = step_fn(mode_in, q_q, D, Sin);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        q_d       = q_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;
        ctr_clear = 1'b0;
        if (Set) begin
            q_d       = '1;
            state_d   = IDLE;
            ctr_clear = 1'b1;
        end else if (state_q == RUN) begin
            q_d     = seq_res[WIDTH-1:0];
            ctr_dec = 1'b1;
            if (ctr_zero) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (Start && is_seq_mode(mode_in)) begin
            op_d = mode_in;
            if (step_cnt == '0) begin
                done_d = 1'b1;
            end else begin
                state_d  = RUN;
                ctr_load = 1'b1;
            end
        end else if (En) begin
            q_d    = single_res[WIDTH-1:0];
            wrap_d = single_res[WIDTH];
        end
    end

    // The counter holds steps remaining after the current one, so zero marks the last.
    usr_step_ctr #(
        .AW(AW)
    ) u_step_ctr (
        .clk      (Clk),
        .rst      (Clr),
        .load     (ctr_load),
        .load_val (step_cnt - AW'(1)),
        .dec      (ctr_dec),
        .clear    (ctr_clear),
        .cnt      (ctr_cnt),
        .zero     (ctr_zero)
    );

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
            op_q    <= MODE_HOLD;
            q_q     <= CLR_VAL;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            q_q     <= q_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Q     = q_q;
    assign SoutL = q_q[WIDTH-1];
    assign SoutR = q_q[0];
    assign Busy  = (state_q == RUN);
    assign Done  = done_q;
    assign Wrap  = wrap_q;

    logic unused_ok;
    assign unused_ok = ^ctr_cnt;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg at WIDTH=8, CLR_VAL=0.
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int AW = $clog2(W + 1);

    logic          Clk = 1'b0;
    logic          Clr, Set, En, Sin, Start;
    logic [2:0]    Mode;
    logic [W-1:0]  D;
    logic [AW-1:0] Amount;
    logic [W-1:0]  Q;
    logic          SoutL, SoutR, Busy, Done, Wrap;

    int checks   = 0;
    int failures = 0;

    universal_shift_reg #(.WIDTH(W), .CLR_VAL(8'h00)) dut (
        .Clk(Clk), .Clr(Clr), .Set(Set), .En(En), .Mode(Mode), .D(D), .Sin(Sin),
        .Start(Start), .Amount(Amount), .Q(Q), .SoutL(SoutL), .SoutR(SoutR),
        .Busy(Busy), .Done(Done), .Wrap(Wrap)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Set = 0; En = 0; Start = 0; Mode = 3'd0; D = '0; Sin = 0; Amount = '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        Mode = 3'd1; D = v; En = 1;
        tick();
        idle_inputs();
    endtask

    task automatic single(input logic [2:0] m);
        Mode = m; En = 1;
        tick();
        idle_inputs();
    endtask

    int busy_cycles;
    int budget;

    initial begin
        idle_inputs();
        Clr = 1;
        #2;
        check("reset_q", Q, 8'h00);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_wrap", Wrap, 0);
        #10;
        Clr = 0;
        tick();

        // Async clear mid-cycle while a sequence is running
        load(8'hA5);
        Mode = 3'd4; Amount = 4; Start = 1;
        tick();
        idle_inputs();
        check("clr_pre_busy", Busy, 1);
        check("clr_pre_q", Q, 8'hA5);
        #2 Clr = 1;
        #1;
        check("clr_async_q", Q, 8'h00);
        check("clr_async_busy", Busy, 0);
        check("clr_async_done", Done, 0);
        #1 Clr = 0;
        tick();
        check("clr_stays_idle", Busy, 0);

        // Load / rotate / set
        load(8'h81);
        check("load_81", Q, 8'h81);
        check("soutl", SoutL, 1);
        check("soutr", SoutR, 1);
        single(3'd4);
        check("rotl_1", Q, 8'h03);
        single(3'd5);
        check("rotr_1", Q, 8'h81);
        Set = 1; En = 1; Mode = 3'd1; D = 8'h12;
        tick();
        idle_inputs();
        check("set_over_en", Q, 8'hFF);

        // Count wrap both directions
        single(3'd6);
        check("cntup_wrap_q", Q, 8'h00);
        check("cntup_wrap_flag", Wrap, 1);
        tick();
        check("wrap_one_cycle", Wrap, 0);
        single(3'd7);
        check("cntdn_wrap_q", Q, 8'hFF);
        check("cntdn_wrap_flag", Wrap, 1);
        single(3'd7);
        check("cntdn_no_wrap_q", Q, 8'hFE);
        check("cntdn_no_wrap_flag", Wrap, 0);

        // Start with a non-sequence mode falls through to the En path
        Start = 1; Mode = 3'd1; D = 8'h01; En = 1; Amount = 3;
        tick();
        idle_inputs();
        check("start_load_q", Q, 8'h01);
        check("start_load_busy", Busy, 0);

        // SHL x3 with Sin=1, En toggling throughout
        Start = 1; Mode = 3'd2; Amount = 3; Sin = 1;
        tick();
        Start = 0;
        check("shl_busy_t0", Busy, 1);
        check("shl_q_t0", Q, 8'h01);
        busy_cycles = 0;
        budget = 0;
        while (Busy && budget < 20) begin
            busy_cycles++;
            budget++;
            En = ~En; Mode = 3'd1; D = 8'h55;
            tick();
        end
        idle_inputs();
        check("shl_busy_cycles", busy_cycles, 3);
        check("shl_q", Q, 8'h0F);
        check("shl_done", Done, 1);
        tick();
        check("shl_done_pulse", Done, 0);

        // SHR with Amount beyond WIDTH saturates at 8 steps
        Start = 1; Mode = 3'd3; Amount = 12; Sin = 0;
        tick();
        Start = 0;
        busy_cycles = 0;
        budget = 0;
        while (Busy && budget < 30) begin
            busy_cycles++;
            budget++;
            tick();
        end
        idle_inputs();
        check("shr_sat_cycles", busy_cycles, 8);
        check("shr_sat_q", Q, 8'h00);
        check("shr_sat_done", Done, 1);

        // Zero-length sequence
        load(8'h3C);
        Start = 1; Mode = 3'd3; Amount = 0;
        tick();
        idle_inputs();
        check("zero_busy", Busy, 0);
        check("zero_done", Done, 1);
        check("zero_q", Q, 8'h3C);
        tick();
        check("zero_done_clear", Done, 0);

        // ROTL x5 aborted by Set at step 2
        load(8'h81);
        Start = 1; Mode = 3'd4; Amount = 5;
        tick();
        idle_inputs();
        tick();
        check("abort_step1", Q, 8'h03);
        Set = 1;
        tick();
        idle_inputs();
        check("abort_q", Q, 8'hFF);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        tick();
        check("abort_no_done_later", Done, 0);
        check("abort_q_hold", Q, 8'hFF);

        // ROTR x2, then back-to-back ROTR x1 started in the Done cycle
        load(8'h81);
        Start = 1; Mode = 3'd5; Amount = 2;
        tick();
        idle_inputs();
        tick();
        check("rotr_seq_1", Q, 8'hC0);
        tick();
        check("rotr_seq_2", Q, 8'h60);
        check("rotr_seq_done", Done, 1);
        Start = 1; Mode = 3'd5; Amount = 1;
        tick();
        idle_inputs();
        check("b2b_busy", Busy, 1);
        check("b2b_done_low", Done, 0);
        check("b2b_q_t0", Q, 8'h60);
        tick();
        check("b2b_q", Q, 8'h30);
        check("b2b_done", Done, 1);
        check("b2b_busy_end", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
